// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: owns the PC, drives the instruction memory and
// presents one latched instruction per two cycles to the control decoder.
module instr_fetch #(
    parameter int                PC_W    = 10,
    parameter int                IW      = 9,
    parameter int                OPW     = 4,
    parameter logic [PC_W-1:0]   LAST_PC = '1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Stall,
    input  logic              Branch,
    input  logic              Zero,
    input  logic [PC_W-1:0]   Target,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [IW-1:0]     imem_data,
    output logic [IW-1:0]     Instr,
    output logic [OPW-1:0]    Opcode,
    output logic              InstrValid,
    output logic [PC_W-1:0]   PC,
    output logic              Done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ISSUE,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   w_pc_next;
    logic [IW-1:0]     r_instr;
    logic [IW-1:0]     w_instr_next;
    logic              r_valid;
    logic              w_valid_next;
    logic              r_done;
    logic              w_done_next;
    logic              w_taken;

    assign w_taken = Branch & Zero;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_instr <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_instr <= w_instr_next;
            r_valid <= w_valid_next;
            r_done  <= w_done_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_instr_next = r_instr;
        w_valid_next = r_valid;
        w_done_next  = r_done;
        case (r_state)
            S_IDLE: begin
                if (Start) begin
                    w_pc_next    = '0;
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                // Memory has had the PC as address for a full cycle; capture its word.
                w_instr_next = imem_data;
                w_valid_next = 1'b1;
                w_state_next = S_ISSUE;
            end
            S_ISSUE: begin
                if (!Stall) begin
                    w_valid_next = 1'b0;
                    // A taken branch always continues, even from the last address.
                    if (w_taken) begin
                        w_pc_next    = Target;
                        w_state_next = S_WAIT;
                    end else if (r_pc == LAST_PC) begin
                        w_done_next  = 1'b1;
                        w_state_next = S_DONE;
                    end else begin
                        w_pc_next    = r_pc + PC_W'(1);
                        w_state_next = S_WAIT;
                    end
                end
            end
            S_DONE: begin
                if (Start) begin
                    w_done_next  = 1'b0;
                    w_pc_next    = '0;
                    w_state_next = S_WAIT;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign imem_addr  = r_pc;
    assign PC         = r_pc;
    assign Instr      = r_instr;
    assign Opcode     = r_instr[IW-1 -: OPW];
    assign InstrValid = r_valid;
    assign Done       = r_done;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a 10-bit-PC instance with LAST_PC=2 and a
// 4-bit-PC instance with LAST_PC=15, each fed from a combinational memory model.
module tb_instr_fetch;

    logic Clk;
    logic Reset;

    // Instance A: PC_W=10, LAST_PC=2
    logic        a_start, a_stall, a_zero, a_branch;
    logic [9:0]  a_target, a_imem_addr, a_pc;
    logic [8:0]  a_imem_data, a_instr;
    logic [3:0]  a_opcode;
    logic        a_valid, a_done;
    logic [8:0]  a_mem [1024];

    // Instance C: PC_W=4, LAST_PC=15
    logic        c_start, c_stall, c_zero, c_branch;
    logic [3:0]  c_target, c_imem_addr, c_pc;
    logic [8:0]  c_imem_data, c_instr;
    logic [3:0]  c_opcode;
    logic        c_valid, c_done;
    logic [8:0]  c_mem [16];

    int n_checks = 0;
    int n_fail   = 0;

    // Bench plays the decoder: biz opcode is 4'b1010.
    assign a_branch    = (a_opcode == 4'hA);
    assign c_branch    = (c_opcode == 4'hA);
    assign a_imem_data = a_mem[a_imem_addr];
    assign c_imem_data = c_mem[c_imem_addr];

    instr_fetch #(.PC_W(10), .IW(9), .OPW(4), .LAST_PC(10'd2)) dut_a (
        .Clk(Clk), .Reset(Reset), .Start(a_start), .Stall(a_stall),
        .Branch(a_branch), .Zero(a_zero), .Target(a_target),
        .imem_addr(a_imem_addr), .imem_data(a_imem_data),
        .Instr(a_instr), .Opcode(a_opcode), .InstrValid(a_valid),
        .PC(a_pc), .Done(a_done)
    );

    instr_fetch #(.PC_W(4), .IW(9), .OPW(4), .LAST_PC(4'd15)) dut_c (
        .Clk(Clk), .Reset(Reset), .Start(c_start), .Stall(c_stall),
        .Branch(c_branch), .Zero(c_zero), .Target(c_target),
        .imem_addr(c_imem_addr), .imem_data(c_imem_data),
        .Instr(c_instr), .Opcode(c_opcode), .InstrValid(c_valid),
        .PC(c_pc), .Done(c_done)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        start;
        logic        stall;
        logic        zero;
        logic [9:0]  target;
        logic        exp_valid;
        logic [9:0]  exp_pc;
        logic [3:0]  exp_op;
        logic        exp_done;
    } vec_t;

    vec_t tbl1 [10];
    vec_t tbl2 [20];

    function automatic vec_t mk(input int s, input int st, input int z, input int t,
                                input int v, input int pc, input int op, input int d);
        vec_t r;
        r.start     = s[0];
        r.stall     = st[0];
        r.zero      = z[0];
        r.target    = 10'(t);
        r.exp_valid = v[0];
        r.exp_pc    = 10'(pc);
        r.exp_op    = 4'(op);
        r.exp_done  = d[0];
        return r;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h required %0h", name, idx, act, exp);
        end
    endtask

    task automatic apply_a(input vec_t v, input string tag, input int idx);
        @(negedge Clk);
        a_start  = v.start;
        a_stall  = v.stall;
        a_zero   = v.zero;
        a_target = v.target;
        @(posedge Clk);
        #1;
        $display("%s[%0d] pc=%0d valid=%0b op=%0h done=%0b", tag, idx, a_pc, a_valid, a_opcode, a_done);
        chk({tag, ".valid"}, idx, 32'(a_valid),     32'(v.exp_valid));
        chk({tag, ".pc"},    idx, 32'(a_pc),        32'(v.exp_pc));
        chk({tag, ".addr"},  idx, 32'(a_imem_addr), 32'(v.exp_pc));
        chk({tag, ".op"},    idx, 32'(a_opcode),    32'(v.exp_op));
        chk({tag, ".done"},  idx, 32'(a_done),      32'(v.exp_done));
    endtask

    task automatic step_c(input logic s, input logic z, input logic [3:0] t);
        @(negedge Clk);
        c_start  = s;
        c_zero   = z;
        c_target = t;
        @(posedge Clk);
        #1;
        $display("c pc=%0d valid=%0b op=%0h done=%0b", c_pc, c_valid, c_opcode, c_done);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        a_start = 0; a_stall = 0; a_zero = 0; a_target = '0;
        c_start = 0; c_stall = 0; c_zero = 0; c_target = '0;
        for (int i = 0; i < 1024; i++) a_mem[i] = '0;
        for (int i = 0; i < 16; i++)   c_mem[i] = '0;
        a_mem[0] = 9'h020; a_mem[1] = 9'h041; a_mem[2] = 9'h062;
        c_mem[0] = 9'h140; c_mem[15] = 9'h140; c_mem[2] = 9'h040;

        // start, stall, zero, target | valid, pc, op, done
        tbl1[0] = mk(1,0,0,0,  0,0,0,0);
        tbl1[1] = mk(0,0,0,0,  1,0,1,0);
        tbl1[2] = mk(0,0,0,0,  0,1,1,0);
        tbl1[3] = mk(0,0,0,0,  1,1,2,0);
        tbl1[4] = mk(1,0,0,0,  0,2,2,0);   // Start in ISSUE ignored
        tbl1[5] = mk(0,0,0,0,  1,2,3,0);
        tbl1[6] = mk(0,0,0,0,  0,2,3,1);
        tbl1[7] = mk(0,0,0,0,  0,2,3,1);
        tbl1[8] = mk(1,0,0,0,  0,0,3,0);   // restart from DONE
        tbl1[9] = mk(0,0,0,0,  1,0,1,0);

        tbl2[0]  = mk(1,0,0,0,   0,0,0,0);
        tbl2[1]  = mk(0,0,0,0,   1,0,10,0);
        tbl2[2]  = mk(0,0,1,3,   0,3,10,0);
        tbl2[3]  = mk(0,0,0,0,   1,3,10,0);
        tbl2[4]  = mk(0,0,1,40,  0,40,10,0);
        tbl2[5]  = mk(0,0,0,0,   1,40,7,0);
        tbl2[6]  = mk(0,0,1,99,  0,41,7,0);  // Zero without Branch
        tbl2[7]  = mk(0,0,0,0,   1,41,10,0);
        tbl2[8]  = mk(0,0,1,3,   0,3,10,0);
        tbl2[9]  = mk(0,0,0,0,   1,3,10,0);
        tbl2[10] = mk(0,0,0,40,  0,4,10,0);  // biz not taken
        tbl2[11] = mk(0,0,0,0,   1,4,4,0);
        tbl2[12] = mk(0,0,0,0,   0,5,4,0);
        tbl2[13] = mk(0,1,0,0,   1,5,5,0);   // Stall in WAIT ignored
        tbl2[14] = mk(0,1,1,0,   1,5,5,0);
        tbl2[15] = mk(0,1,0,0,   1,5,5,0);
        tbl2[16] = mk(0,1,0,0,   1,5,5,0);
        tbl2[17] = mk(0,0,0,0,   0,6,5,0);
        tbl2[18] = mk(0,0,0,0,   1,6,6,0);
        tbl2[19] = mk(0,0,0,0,   0,7,6,0);

        #12;
        Reset = 1'b0;
        #1;
        chk("reset.valid", 0, 32'(a_valid), 32'd0);
        chk("reset.pc",    0, 32'(a_pc),    32'd0);
        chk("reset.instr", 0, 32'(a_instr), 32'd0);
        chk("reset.done",  0, 32'(a_done),  32'd0);

        for (int i = 0; i < 10; i++) apply_a(tbl1[i], "run1", i);

        do_reset();
        a_mem[0]  = 9'h140; a_mem[3]  = 9'h140; a_mem[4] = 9'h080;
        a_mem[5]  = 9'h0A0; a_mem[6]  = 9'h0C0; a_mem[40] = 9'h0E0;
        a_mem[41] = 9'h140;
        for (int i = 0; i < 20; i++) apply_a(tbl2[i], "run2", i);

        // Asynchronous reset mid-WAIT at PC 7
        #2;
        Reset = 1'b1;
        #1;
        chk("areset.valid", 0, 32'(a_valid),  32'd0);
        chk("areset.pc",    0, 32'(a_pc),     32'd0);
        chk("areset.instr", 0, 32'(a_instr),  32'd0);
        chk("areset.done",  0, 32'(a_done),   32'd0);
        @(negedge Clk);
        Reset   = 1'b0;
        a_start = 1'b1;
        @(posedge Clk);
        #1;
        chk("resume.pc",    0, 32'(a_pc),    32'd0);
        chk("resume.valid", 0, 32'(a_valid), 32'd0);
        @(negedge Clk);
        a_start = 1'b0;
        @(posedge Clk);
        #1;
        chk("resume.valid", 1, 32'(a_valid),  32'd1);
        chk("resume.op",    1, 32'(a_opcode), 32'hA);

        // Instance C: taken branch at LAST_PC continues, fall-through ends
        do_reset();
        step_c(1, 0, 0);
        chk("c.pc", 0, 32'(c_pc), 32'd0);
        step_c(0, 0, 0);
        chk("c.op", 0, 32'(c_opcode), 32'hA);
        step_c(0, 1, 4'd15);
        chk("c.pc", 1, 32'(c_pc), 32'd15);
        step_c(0, 0, 0);
        chk("c.valid", 1, 32'(c_valid), 32'd1);
        step_c(0, 1, 4'd2);
        chk("c.done", 2, 32'(c_done), 32'd0);
        chk("c.pc",   2, 32'(c_pc),   32'd2);
        for (int p = 2; p < 15; p++) begin
            step_c(0, 0, 0);
            chk("c.issue_pc", p, 32'(c_pc),    32'(p));
            chk("c.issue_v",  p, 32'(c_valid), 32'd1);
            step_c(0, 0, 0);
            chk("c.wait_pc",  p, 32'(c_pc),    32'(p + 1));
        end
        step_c(0, 0, 0);
        chk("c.last_op", 0, 32'(c_opcode), 32'hA);
        step_c(0, 0, 4'd2);
        chk("c.done",  3, 32'(c_done),  32'd1);
        chk("c.pc",    3, 32'(c_pc),    32'd15);
        chk("c.valid", 3, 32'(c_valid), 32'd0);
        step_c(0, 0, 0);
        chk("c.done",  4, 32'(c_done),  32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
